// File: rtl/control_sequencer_pkg.sv
// Shared constants for the DataPath control sequencer: state encoding,
// opcode values, opcode classes and the decoded control-word layout.
package control_sequencer_pkg;

    localparam int              OP_W       = 5;
    localparam logic [OP_W-1:0] ADD_OP_DEF = 5'b00011;

    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_T7   = 4'd8,
        ST_HALT = 4'd9
    } state_e;

    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    typedef enum logic [2:0] {
        CLS_LD   = 3'd0,
        CLS_LDI  = 3'd1,
        CLS_ST   = 3'd2,
        CLS_ALU  = 3'd3,
        CLS_ADDI = 3'd4,
        CLS_NOP  = 3'd5,
        CLS_HALT = 3'd6
    } op_cls_e;

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic rz_in;
        logic rzlo_out;
        logic pc_in;
        logic read;
        logic write;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic ry_in;
        logic c_out;
        logic gra;
        logic grb;
        logic grc;
        logic rin;
        logic rout;
        logic ba_out;
        logic run;
    } ctrl_t;

    // Undefined opcodes fold into the halt class so they stop the machine.
    function automatic op_cls_e op_class(input logic [OP_W-1:0] op);
        op_cls_e cls;
        case (op)
            OP_LD:   cls = CLS_LD;
            OP_LDI:  cls = CLS_LDI;
            OP_ST:   cls = CLS_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR: cls = CLS_ALU;
            OP_ADDI: cls = CLS_ADDI;
            OP_NOP:  cls = CLS_NOP;
            default: cls = CLS_HALT;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/control_sequencer_cs_decode.sv
// Purely combinational decoder: current state plus latched opcode to the
// full DataPath control word and ALU operation.
module cs_decode
    import control_sequencer_pkg::*;
#(
    parameter int              OPW    = OP_W,
    parameter logic [OPW-1:0]  ADD_OP = ADD_OP_DEF
) (
    input  state_e           state_i,
    input  logic [OPW-1:0]   op_i,
    output ctrl_t            ctrl_o,
    output logic [OPW-1:0]   ops_o
);

    op_cls_e cls_s;

    // Control word decode; everything not named for a state stays low.
    always_comb begin
        ctrl_o = '0;
        ops_o  = '0;
        cls_s  = op_class(op_i);
        ctrl_o.run = (state_i != ST_RST) && (state_i != ST_HALT);
        case (state_i)
            ST_T0: begin
                ctrl_o.pc_out = 1'b1; ctrl_o.mar_in = 1'b1;
                ctrl_o.inc_pc = 1'b1; ctrl_o.rz_in  = 1'b1;
            end
            ST_T1: begin
                ctrl_o.rzlo_out = 1'b1; ctrl_o.pc_in  = 1'b1;
                ctrl_o.read     = 1'b1; ctrl_o.mdr_in = 1'b1;
            end
            ST_T2: begin
                ctrl_o.mdr_out = 1'b1; ctrl_o.ir_in = 1'b1;
            end
            ST_T3: begin
                case (cls_s)
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        ctrl_o.grb = 1'b1; ctrl_o.ba_out = 1'b1; ctrl_o.ry_in = 1'b1;
                    end
                    CLS_ALU, CLS_ADDI: begin
                        ctrl_o.grb = 1'b1; ctrl_o.rout = 1'b1; ctrl_o.ry_in = 1'b1;
                    end
                    default: ctrl_o.ry_in = 1'b0;
                endcase
            end
            ST_T4: begin
                case (cls_s)
                    CLS_LD, CLS_LDI, CLS_ST, CLS_ADDI: begin
                        ctrl_o.c_out = 1'b1; ctrl_o.rz_in = 1'b1; ops_o = ADD_OP;
                    end
                    CLS_ALU: begin
                        ctrl_o.grc = 1'b1; ctrl_o.rout = 1'b1; ctrl_o.rz_in = 1'b1;
                        ops_o = op_i;
                    end
                    default: ops_o = '0;
                endcase
            end
            ST_T5: begin
                case (cls_s)
                    CLS_LD, CLS_ST: begin
                        ctrl_o.rzlo_out = 1'b1; ctrl_o.mar_in = 1'b1;
                    end
                    CLS_LDI, CLS_ALU, CLS_ADDI: begin
                        ctrl_o.rzlo_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.rin = 1'b1;
                    end
                    default: ctrl_o.rin = 1'b0;
                endcase
            end
            ST_T6: begin
                case (cls_s)
                    CLS_LD: begin
                        ctrl_o.read = 1'b1; ctrl_o.mdr_in = 1'b1;
                    end
                    // Read stays low so MDR takes the register value off the bus.
                    CLS_ST: begin
                        ctrl_o.gra = 1'b1; ctrl_o.rout = 1'b1; ctrl_o.mdr_in = 1'b1;
                    end
                    default: ctrl_o.mdr_in = 1'b0;
                endcase
            end
            ST_T7: begin
                case (cls_s)
                    CLS_LD: begin
                        ctrl_o.mdr_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.rin = 1'b1;
                    end
                    CLS_ST:  ctrl_o.write = 1'b1;
                    default: ctrl_o.write = 1'b0;
                endcase
            end
            default: ctrl_o.run = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore sequencer for the single-bus DataPath: state register, opcode latch
// and next-state logic; control lines come from cs_decode.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int              OPW    = OP_W,
    parameter logic [OPW-1:0]  ADD_OP = ADD_OP_DEF
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [OPW-1:0]  ir_op,
    input  logic            mem_ready,
    output logic            PCout,
    output logic            MARin,
    output logic            IncPC,
    output logic            RZin,
    output logic            RZLOout,
    output logic            PCin,
    output logic            Read,
    output logic            Write,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            RYin,
    output logic            Cout,
    output logic            gra,
    output logic            grb,
    output logic            grc,
    output logic            rin,
    output logic            rout,
    output logic            BAout,
    output logic [OPW-1:0]  ops,
    output logic            run,
    output logic [3:0]      state_dbg
);

    state_e          state_q, state_d;
    logic [OPW-1:0]  op_q, op_d;
    ctrl_t           ctrl_s;
    op_cls_e         cur_cls_s, live_cls_s;

    // Next-state and opcode-latch logic.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cur_cls_s  = op_class(op_q);
        live_cls_s = op_class(ir_op);
        case (state_q)
            ST_RST: state_d = ST_T0;
            ST_T0:  state_d = ST_T1;
            ST_T1:  state_d = mem_ready ? ST_T2 : ST_T1;
            ST_T2: begin
                case (live_cls_s)
                    CLS_NOP:  state_d = ST_T0;
                    CLS_HALT: state_d = ST_HALT;
                    default:  state_d = ST_T3;
                endcase
            end
            ST_T3: state_d = ST_T4;
            ST_T4: state_d = ST_T5;
            ST_T5: begin
                case (cur_cls_s)
                    CLS_LD, CLS_ST:             state_d = ST_T6;
                    CLS_LDI, CLS_ALU, CLS_ADDI: state_d = ST_T0;
                    default:                    state_d = ST_HALT;
                endcase
            end
            ST_T6: begin
                case (cur_cls_s)
                    CLS_LD:  state_d = mem_ready ? ST_T7 : ST_T6;
                    CLS_ST:  state_d = ST_T7;
                    default: state_d = ST_HALT;
                endcase
            end
            ST_T7: begin
                case (cur_cls_s)
                    CLS_LD:  state_d = ST_T0;
                    CLS_ST:  state_d = mem_ready ? ST_T0 : ST_T7;
                    default: state_d = ST_HALT;
                endcase
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
        if ((state_q == ST_T2) && (state_d == ST_T3)) begin
            op_d = ir_op;
        end else begin
            op_d = op_q;
        end
    end

    // State register and opcode latch.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= ST_RST;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    cs_decode #(
        .OPW    (OPW),
        .ADD_OP (ADD_OP)
    ) u_decode (
        .state_i (state_q),
        .op_i    (op_q),
        .ctrl_o  (ctrl_s),
        .ops_o   (ops)
    );

    assign PCout     = ctrl_s.pc_out;
    assign MARin     = ctrl_s.mar_in;
    assign IncPC     = ctrl_s.inc_pc;
    assign RZin      = ctrl_s.rz_in;
    assign RZLOout   = ctrl_s.rzlo_out;
    assign PCin      = ctrl_s.pc_in;
    assign Read      = ctrl_s.read;
    assign Write     = ctrl_s.write;
    assign MDRin     = ctrl_s.mdr_in;
    assign MDRout    = ctrl_s.mdr_out;
    assign IRin      = ctrl_s.ir_in;
    assign RYin      = ctrl_s.ry_in;
    assign Cout      = ctrl_s.c_out;
    assign gra       = ctrl_s.gra;
    assign grb       = ctrl_s.grb;
    assign grc       = ctrl_s.grc;
    assign rin       = ctrl_s.rin;
    assign rout      = ctrl_s.rout;
    assign BAout     = ctrl_s.ba_out;
    assign run       = ctrl_s.run;
    assign state_dbg = state_q;

endmodule
